// File: rtl/pipe_mem_unit.sv
// Purpose: multi-cycle data-memory stage with byte/half/word loads and stores over a synchronous word RAM.
// Latency: accept -> resp_valid in WAIT_CYCLES+2 cycles (1 cycle on a faulting request); one request in flight.
// Backpressure: req_ready is high only in IDLE; resp_valid is a one-cycle pulse that cannot be stalled.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready    request handshake; accepted when both are high on a rising edge
//   req_we, req_size         1 = store; 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned             loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata      byte address; right-aligned store data
//   resp_valid, resp_rdata   completion pulse; extended load data (0 for stores and faults)
//   resp_err                 request faulted, no RAM access was made
//   badvaddr                 address of the most recent faulting request
module pipe_mem_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] badvaddr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Counter is loaded with WAIT_CYCLES-1 so that exactly WAIT_CYCLES cycles are spent in WAIT.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]            state;
    logic [3:0]            wait_cnt;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  err_q;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           ram_q;

    logic                  accept;
    logic                  req_err;
    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            lane_en;
    logic [31:0]           lane_dat;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_dat;

    assign accept   = req_valid && (state == S_IDLE);
    assign req_ready = (state == S_IDLE);
    assign ram_en   = (state == S_ACCESS);
    assign word_idx = addr_q[ADDR_WIDTH+1:2];

    // Fault detection on the live request fields; only meaningful in the accept cycle.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b11:   req_err = 1'b1;
            2'b10:   req_err = |req_addr[1:0];
            2'b01:   req_err = req_addr[0];
            default: req_err = 1'b0;
        endcase
        if ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
            req_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            badvaddr <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr[ADDR_WIDTH+1:0];
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        if (req_err) begin
                            badvaddr <= req_addr;
                            state    <= S_RESP;
                        end else if (WAIT_CYCLES > 0) begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= S_WAIT;
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACCESS: state <= S_RESP;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Store lane enables and lane-replicated write data; reserved size never reaches ACCESS.
    always_comb begin
        lane_en  = 4'b1111;
        lane_dat = wdata_q;
        case (size_q)
            2'b00: begin
                lane_en  = 4'b0001 << addr_q[1:0];
                lane_dat = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_en  = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_en  = 4'b1111;
                lane_dat = wdata_q;
            end
        endcase
    end

    // RAM contents survive reset; the write enable is cut by the async state reset,
    // so a store dropped before its ACCESS edge never lands.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (we_q) begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_en[i]) begin
                        mem[word_idx][8*i +: 8] <= lane_dat[8*i +: 8];
                    end
                end
            end else begin
                ram_q <= mem[word_idx];
            end
        end
    end

    assign byte_sel = ram_q[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? ram_q[31:16] : ram_q[15:0];

    always_comb begin
        load_dat = ram_q;
        case (size_q)
            2'b00:   load_dat = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_dat = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_dat = ram_q;
        endcase
    end

    assign resp_valid = (state == S_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !we_q) ? load_dat : 32'd0;

endmodule

// File: tb/tb_pipe_mem_unit.sv
module tb_pipe_mem_unit;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n0, rst_n3;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        sel;

    logic        req_valid0, req_valid3;
    logic        ready0, ready3, rv0, rv3, re0, re3;
    logic [31:0] rd0, rd3, bad0, bad3;

    logic        m_ready, m_rv, m_re;
    logic [31:0] m_rd, m_bad;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] bad_exp [2];
    vec_t        tbl [$];

    always #5 clk = ~clk;

    assign req_valid0 = req_valid && !sel;
    assign req_valid3 = req_valid && sel;

    always_comb begin
        m_ready = sel ? ready3 : ready0;
        m_rv    = sel ? rv3 : rv0;
        m_re    = sel ? re3 : re0;
        m_rd    = sel ? rd3 : rd0;
        m_bad   = sel ? bad3 : bad0;
    end

    pipe_mem_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n0),
        .req_valid(req_valid0), .req_ready(ready0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0), .badvaddr(bad0)
    );

    pipe_mem_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n3),
        .req_valid(req_valid3), .req_ready(ready3),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(re3), .badvaddr(bad3)
    );

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
    endtask

    // Counts falling edges after an accept edge until resp_valid is seen (bounded).
    task automatic wait_resp(output int lat);
        bit got;
        got = 0;
        lat = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (m_rv) got = 1;
        end
    endtask

    task automatic run_req(input vec_t v, input string nm);
        int lat;
        int exp_lat;
        exp_lat = v.err ? 1 : (sel ? 5 : 2);
        @(negedge clk);
        drive(v);
        req_valid = 1'b1;
        chk({nm, " ready_before"}, 32'(m_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        if (v.err) bad_exp[sel] = v.addr;
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " rdata"}, m_rd, v.rdata);
        chk({nm, " err"}, 32'(m_re), 32'(v.err));
        chk({nm, " badvaddr"}, m_bad, bad_exp[sel]);
        @(negedge clk);
        chk({nm, " pulse_end"}, 32'(m_rv), 32'd0);
        chk({nm, " ready_after"}, 32'(m_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, low, rv_cyc, acc_cyc, pulses;

        sel = 1'b0;
        rst_n0 = 1'b0;
        rst_n3 = 1'b0;
        req_valid = 1'b0;
        drive(mk(1'b0, SZ_W, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0));
        bad_exp[0] = 32'd0;
        bad_exp[1] = 32'd0;

        #12;
        chk("rst ready", 32'(ready0), 32'd1);
        chk("rst resp_valid", 32'(rv0), 32'd0);
        chk("rst resp_err", 32'(re0), 32'd0);
        chk("rst rdata", rd0, 32'd0);
        chk("rst badvaddr", bad0, 32'd0);
        chk("rst badvaddr3", bad3, 32'd0);
        #10;
        rst_n0 = 1'b1;
        rst_n3 = 1'b1;

        // we, size, uns, addr, wdata, expected rdata, expected err
        tbl.push_back(mk(1, SZ_W, 0, 32'h10,  32'h8899AABB, 32'h0,        0));
        tbl.push_back(mk(0, SZ_W, 0, 32'h10,  32'h0,        32'h8899AABB, 0));
        tbl.push_back(mk(1, SZ_B, 0, 32'h13,  32'h000000F0, 32'h0,        0));
        tbl.push_back(mk(0, SZ_B, 0, 32'h13,  32'h0,        32'hFFFFFFF0, 0));
        tbl.push_back(mk(0, SZ_B, 1, 32'h13,  32'h0,        32'h000000F0, 0));
        tbl.push_back(mk(0, SZ_W, 0, 32'h10,  32'h0,        32'hF099AABB, 0));
        tbl.push_back(mk(0, SZ_H, 0, 32'h12,  32'h0,        32'hFFFFF099, 0));
        tbl.push_back(mk(1, SZ_W, 0, 32'h20,  32'hFFFFFFFF, 32'h0,        0));
        tbl.push_back(mk(1, SZ_H, 0, 32'h22,  32'h00001234, 32'h0,        0));
        tbl.push_back(mk(0, SZ_H, 0, 32'h22,  32'h0,        32'h00001234, 0));
        tbl.push_back(mk(0, SZ_W, 0, 32'h20,  32'h0,        32'h1234FFFF, 0));
        tbl.push_back(mk(0, SZ_H, 0, 32'h20,  32'h0,        32'hFFFFFFFF, 0));
        tbl.push_back(mk(0, SZ_H, 1, 32'h20,  32'h0,        32'h0000FFFF, 0));
        tbl.push_back(mk(0, SZ_B, 0, 32'h20,  32'h0,        32'hFFFFFFFF, 0));
        tbl.push_back(mk(0, SZ_W, 0, 32'h06,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0, SZ_W, 0, 32'h10,  32'h0,        32'hF099AABB, 0));
        tbl.push_back(mk(0, SZ_R, 0, 32'h14,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0, SZ_W, 0, 32'h400, 32'h0,        32'h0,        1));
        tbl.push_back(mk(1, SZ_W, 0, 32'h00,  32'h11223344, 32'h0,        0));
        tbl.push_back(mk(1, SZ_W, 0, 32'h400, 32'hDEADBEEF, 32'h0,        1));
        tbl.push_back(mk(1, SZ_H, 0, 32'h03,  32'h0000ABCD, 32'h0,        1));
        tbl.push_back(mk(0, SZ_W, 0, 32'h00,  32'h0,        32'h11223344, 0));
        tbl.push_back(mk(1, SZ_B, 0, 32'h01,  32'hFFFFFF55, 32'h0,        0));
        tbl.push_back(mk(0, SZ_W, 0, 32'h00,  32'h0,        32'h11225544, 0));
        tbl.push_back(mk(0, SZ_B, 0, 32'h01,  32'h0,        32'h00000055, 0));
        tbl.push_back(mk(0, SZ_H, 1, 32'h02,  32'h0,        32'h00001122, 0));
        tbl.push_back(mk(0, SZ_H, 0, 32'h01,  32'h0,        32'h0,        1));

        foreach (tbl[i]) run_req(tbl[i], $sformatf("w0_v%0d", i));

        // Three wait states.
        sel = 1'b1;
        run_req(mk(1, SZ_W, 0, 32'h40, 32'hCAFEF00D, 32'h0,        0), "w3_st40");
        run_req(mk(0, SZ_W, 0, 32'h40, 32'h0,        32'hCAFEF00D, 0), "w3_ld40");
        run_req(mk(0, SZ_W, 0, 32'h41, 32'h0,        32'h0,        1), "w3_mis41");

        // Back-to-back: req_valid held high, second request waits for IDLE.
        @(negedge clk);
        drive(mk(1, SZ_W, 0, 32'h44, 32'h11111111, 32'h0, 0));
        req_valid = 1'b1;
        @(posedge clk);
        #1 drive(mk(0, SZ_W, 0, 32'h44, 32'h0, 32'h0, 0));
        low = 0; rv_cyc = 0; acc_cyc = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (!m_ready) low++;
            if (m_rv) rv_cyc = c;
            if (m_ready && acc_cyc == 0) acc_cyc = c;
        end
        chk("b2b ready_low_cycles", 32'(low), 32'd5);
        chk("b2b resp_cycle", 32'(rv_cyc), 32'd5);
        chk("b2b ready_cycle", 32'(acc_cyc), 32'd6);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        chk("b2b ld_latency", 32'(lat), 32'd5);
        chk("b2b ld_rdata", m_rd, 32'h11111111);
        chk("b2b ld_err", 32'(m_re), 32'd0);

        // Reset in cycle 2 of a store: outputs clear at once, store is dropped.
        @(negedge clk);
        drive(mk(1, SZ_W, 0, 32'h40, 32'hBAD0BAD0, 32'h0, 0));
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n3 = 1'b0;
        #1;
        chk("midrst ready", 32'(ready3), 32'd1);
        chk("midrst resp_valid", 32'(rv3), 32'd0);
        chk("midrst rdata", rd3, 32'd0);
        chk("midrst err", 32'(re3), 32'd0);
        chk("midrst badvaddr", bad3, 32'd0);
        bad_exp[1] = 32'd0;
        @(negedge clk);
        rst_n3 = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (rv3) pulses++;
        end
        chk("midrst no_resp", 32'(pulses), 32'd0);
        run_req(mk(0, SZ_W, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0), "w3_ld40_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_mem_unit.md
# pipe_mem_unit

Parametrised, multi-cycle successor to the pipeline data-memory stage. It owns a synchronous word-organised data RAM and accepts one load or store at a time over a valid/ready handshake. It supports byte, halfword and word accesses, with sign or zero extension on loads and byte-lane masking on stores. Alignment, range and size errors are detected at request acceptance; the faulting address is latched for the exception unit. A parametrised wait-state counter emulates slower memory.

## Interface
- ADDR_WIDTH, 8, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words; valid byte range 0 .. 2^(ADDR_WIDTH+2)-1
- WAIT_CYCLES, 0, extra stall cycles inserted before each RAM access (0..15)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle pulse: request completed
- resp_rdata  output  32  extended load data; 0 when resp_valid=0, for stores, or when resp_err=1
- resp_err  output  1  valid with resp_valid: request faulted, no RAM access made
- badvaddr  output  32  address of the most recent faulting request

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP. req_ready = 1 only in IDLE.
- A request is accepted on an edge where state=IDLE and req_valid=1. On acceptance, all req_* fields are registered.
- Error check at acceptance (combinational on req_*):
  - size 11 → error.
  - word with addr[1:0]≠0 → error.
  - half with addr[0]=1 → error.
  - addr[31:ADDR_WIDTH+2]≠0 → error.
  - Byte accesses are never misaligned.
- Error path: IDLE→RESP directly; resp_err=1; badvaddr ← req_addr; no RAM enable, no write.
- Normal path: IDLE→WAIT if WAIT_CYCLES>0, else IDLE→ACCESS.
  - WAIT: down-counter loaded with WAIT_CYCLES-1 on acceptance; move to ACCESS when it reaches 0.
  - ACCESS: RAM enabled for exactly one cycle. Word index = addr[ADDR_WIDTH+1:2]. Then ACCESS→RESP, and RESP→IDLE unconditionally.
- Store lanes: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes {addr[1],0}+1:0 with wdata[15:0]; word writes all four lanes. Unwritten lanes are preserved (per-lane write enables, no read-modify-write).
- Load extraction in RESP, from the RAM output:
  - byte = lane addr[1:0]; half = upper half if addr[1]=1, else lower; word = the whole word.
  - Extension uses bit 7 or bit 15 when req_unsigned=0, otherwise zeros.
- badvaddr changes only on error acceptance.
- RAM contents are not initialised or cleared by reset.

## Timing
- Request accepted at the end of cycle 0.
- Normal path: cycles 1..WAIT_CYCLES are WAIT, cycle WAIT_CYCLES+1 is ACCESS, cycle WAIT_CYCLES+2 is RESP (resp_valid=1). req_ready returns to 1 in cycle WAIT_CYCLES+3.
- Error path: RESP in cycle 1, req_ready=1 in cycle 2.
- Throughput: one request per WAIT_CYCLES+3 cycles. Back-to-back requests each observe the previous store's data.
- resp_valid is high for exactly one cycle per accepted request. It does not depend on any response-ready input; there is no backpressure.
- Requests and field changes while req_ready=0 are ignored.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, badvaddr=0, wait counter 0.
- Reset mid-operation: the FSM returns to IDLE immediately and the pending request is dropped.
  - A store whose ACCESS edge has not yet occurred is not written.
  - No resp_valid is produced for the dropped request.

## Test plan
- WAIT_CYCLES=0: store word 0x8899AABB to addr 0x10, then load word from 0x10 → resp_valid in cycle 2 after accept, rdata=0x8899AABB, resp_err=0.
- Store byte 0xF0 to 0x13, then load byte signed from 0x13 → 0xFFFFFFF0. Load byte unsigned → 0x000000F0. Load word from 0x10 → 0xF099AABB.
- Store half 0x1234 to 0x22 over word 0xFFFFFFFF, then load half signed from 0x22 → 0x00001234; load word → 0x1234FFFF.
- Load word from 0x0000_0006 → resp_err=1 in cycle 1, rdata=0, badvaddr=0x00000006, RAM unchanged. Repeat with size=11 and with addr=0x400 (ADDR_WIDTH=8) → both error.
- WAIT_CYCLES=3: store word → req_ready low for 5 cycles, resp_valid in cycle 5. Hold req_valid high with a second request → accepted only in cycle 6.
- WAIT_CYCLES=3: assert rst_n=0 in cycle 2 of a store to 0x40 → outputs take reset values immediately; a subsequent load of 0x40 returns the old contents.
